demux_sel_sequencer: RTL

Upstream control stage for the 1x8 demultiplexer. It drives the demux select `s` and data `a` through a programmable scan of the eight output channels. Each channel in the scan is held for a programmable dwell. It produces busy/done status so a controller can launch scans and wait for them to finish. The sequencer's `a` and `s` outputs connect directly to the demux's `a` and `s` inputs.

---
 rtl/demux_sel_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/demux_sel_sequencer.sv
// rtl/demux_sel_sequencer.sv - programmable dwell scan sequencer driving the 1x8 demux select and data
// Optional build macro: DEMUX_SEQ_LOOP_EN (scan wraps to the lowest enabled channel until stop)
module demux_sel_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               din,
  output logic               a,
  output logic [2:0]         s,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         s_q, s_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [7:0]         mask_q, mask_d;

  logic [7:0]         above_mask;
  logic               has_next;
  logic [2:0]         next_ch;

  // Lowest set bit of a channel mask; returns 0 for an empty mask.
  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    logic [2:0] ch;
    ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) ch = 3'(i);
    end
    return ch;
  endfunction

  // Enabled channels strictly above the current select; (2 << s) - 1 covers bits 0..s,
  // and for s=7 the shift overflows to 0 so the subtraction yields all ones.
  always_comb begin
    above_mask = mask_q & ~((8'd2 << s_q) - 8'd1);
    has_next   = |above_mask;
    next_ch    = lowest_ch(above_mask);
  end

  // Next-state logic: launch, dwell countdown, channel advance, termination.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mask != 8'd0) begin
            mask_d  = mask;
            dwell_d = dwell;
            s_d     = lowest_ch(mask);
            cnt_d   = dwell;
            state_d = ST_SCAN;
          end else begin
            // Empty mask: report completion without ever going busy; s is left alone.
            state_d = ST_DONE;
          end
        end
      end
      ST_SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (stop) begin
          state_d = ST_DONE;
        end else if (has_next) begin
          s_d   = next_ch;
          cnt_d = dwell_q;
        end else begin
`ifdef DEMUX_SEQ_LOOP_EN
          s_d   = lowest_ch(mask_q);
          cnt_d = dwell_q;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset abandons any scan without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mask_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mask_q  <= mask_d;
    end
  end

  assign a    = (state_q == ST_SCAN) ? din : 1'b0;
  assign s    = s_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
